// File: rtl/i2s_rx_stereo.sv
// I2S receive master: generates BCLK/LRCLK from clk, captures BIT_DEPTH bits per
// channel slot MSB-first (one-bit I2S delay) and offers each word on a valid/ready port.
module i2s_rx_stereo #(
    parameter int BIT_DEPTH = 18,
    parameter int WORD_SIZE = 32,
    parameter int CLK_DIV   = 4,
    parameter int CH_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sd,
    output logic                 bclk,
    output logic                 lrclk,
    output logic [BIT_DEPTH-1:0] data,
    output logic                 chan,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = $clog2(WORD_SIZE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_SIZE - 1);
    localparam logic [SLOT_W-1:0] SLOT_LSB  = SLOT_W'(BIT_DEPTH);

    logic [DIV_W-1:0]     div_cnt;
    logic [SLOT_W-1:0]    slot;
    logic [BIT_DEPTH-1:0] shift_reg;
    logic [BIT_DEPTH-1:0] shift_next;
    logic                 load_pend;
    logic                 load_chan;

    logic tick, rise, fall, in_window, word_done, chan_on;
    logic load, xfer, drop;

    assign tick      = en && (div_cnt == DIV_LAST);
    assign rise      = tick && !bclk;
    assign fall      = tick && bclk;
    // Slot 0 carries the I2S one-bit delay; bits after the LSB are padding.
    assign in_window = (slot != '0) && (slot <= SLOT_LSB);
    assign word_done = rise && (slot == SLOT_LSB);
    assign chan_on   = (CH_MODE == 1) ? !lrclk :
                       (CH_MODE == 2) ?  lrclk : 1'b1;

    if (BIT_DEPTH > 1) begin : g_shift_wide
        assign shift_next = {shift_reg[BIT_DEPTH-2:0], sd};
    end else begin : g_shift_one
        assign shift_next = sd;
    end

    // Clock generation and capture; disabling behaves like a reset of this half only.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst || !en) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            slot      <= '0;
            shift_reg <= '0;
            load_pend <= 1'b0;
            load_chan <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                bclk <= !bclk;
            if (fall) begin
                if (slot == SLOT_LAST) begin
                    slot  <= '0;
                    lrclk <= !lrclk;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
            if (rise && in_window)
                shift_reg <= shift_next;
            load_pend <= word_done && chan_on;
            load_chan <= lrclk;
        end
    end

    // The word completes at a rise edge; it is handed over one clk later.
    assign load = load_pend && en;
    assign xfer = valid && ready;
    assign drop = load && valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data     <= '0;
            chan     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && !drop) begin
                data  <= shift_reg;
                chan  <= load_chan;
                valid <= 1'b1;
            end else if (xfer) begin
                valid <= 1'b0;
            end
            // A drop on the same edge as a clear request wins.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench: a stereo instance and a right-only instance share clk/rst/en/sd;
// a microphone model drives sd from the stereo instance's BCLK/LRCLK.
module tb_i2s_rx_stereo;

    logic        clk = 1'b0;
    logic        rst, en, sd;
    logic        ready_a, ovf_clr_a, ready_b, ovf_clr_b;
    logic        bclk_a, lrclk_a, chan_a, valid_a, overflow_a;
    logic        bclk_b, lrclk_b, chan_b, valid_b, overflow_b;
    logic [17:0] data_a, data_b;

    logic [17:0] left_word, right_word;
    int          t;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_vb   = 0;
    int          bad_b  = 0;

    always #5 clk = ~clk;

    i2s_rx_stereo #(.BIT_DEPTH(18), .WORD_SIZE(32), .CLK_DIV(2), .CH_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sd(sd),
        .bclk(bclk_a), .lrclk(lrclk_a), .data(data_a), .chan(chan_a),
        .valid(valid_a), .ready(ready_a), .overflow(overflow_a), .ovf_clr(ovf_clr_a)
    );

    i2s_rx_stereo #(.BIT_DEPTH(18), .WORD_SIZE(32), .CLK_DIV(2), .CH_MODE(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sd(sd),
        .bclk(bclk_b), .lrclk(lrclk_b), .data(data_b), .chan(chan_b),
        .valid(valid_b), .ready(ready_b), .overflow(overflow_b), .ovf_clr(ovf_clr_b)
    );

    // Microphone: presents the next bit just after each BCLK fall; MSB one BCLK after LRCLK moves.
    initial begin
        logic        prev_bclk;
        logic        lr_seen;
        logic [17:0] w;
        int          idx;
        sd = 1'b0; prev_bclk = 1'b0; lr_seen = 1'b0; idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !en) begin
                idx = 0; lr_seen = 1'b0; sd = 1'b0;
            end else if (prev_bclk && !bclk_a) begin
                if (lrclk_a != lr_seen) begin
                    lr_seen = lrclk_a; idx = 0; sd = 1'b0;
                end else if (idx < 18) begin
                    w   = lrclk_a ? right_word : left_word;
                    sd  = w[17-idx];
                    idx++;
                end else begin
                    sd = 1'b0;
                end
            end
            prev_bclk = bclk_a;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid_b === 1'b1) begin
                n_vb++;
                if (chan_b !== 1'b1) bad_b++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic step_to(input int target);
        while (t < target) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        ready_a = 1'b1; ovf_clr_a = 1'b0; ready_b = 1'b1; ovf_clr_b = 1'b0;
        left_word = 18'h2A5A5; right_word = 18'h1FFFF;
        t = 0;
        repeat (4) @(negedge clk);
        check("rst_bclk",  {31'd0, bclk_a},     32'd0);
        check("rst_lrclk", {31'd0, lrclk_a},    32'd0);
        check("rst_valid", {31'd0, valid_a},    32'd0);
        check("rst_data",  {14'd0, data_a},     32'd0);
        check("rst_ovf",   {31'd0, overflow_a}, 32'd0);

        // Stereo capture, bclk period 4, lrclk period 256.
        rst = 1'b0; t = 0;
        step_to(1);   check("bclk_t1", {31'd0, bclk_a}, 32'd0);
        step_to(2);   check("bclk_t2", {31'd0, bclk_a}, 32'd1);
        step_to(4);   check("bclk_t4", {31'd0, bclk_a}, 32'd0);
        step_to(6);   check("bclk_t6", {31'd0, bclk_a}, 32'd1);
        step_to(74);  check("left_pre_valid", {31'd0, valid_a}, 32'd0);
        step_to(75);
        check("left_valid", {31'd0, valid_a}, 32'd1);
        check("left_data",  {14'd0, data_a},  32'h2A5A5);
        check("left_chan",  {31'd0, chan_a},  32'd0);
        check("b_no_left",  {31'd0, valid_b}, 32'd0);
        step_to(76);  check("left_pulse_end", {31'd0, valid_a}, 32'd0);
        step_to(127); check("lr_t127", {31'd0, lrclk_a}, 32'd0);
        step_to(128); check("lr_t128", {31'd0, lrclk_a}, 32'd1);
        step_to(202); check("right_pre_valid", {31'd0, valid_a}, 32'd0);
        step_to(203);
        check("right_valid",  {31'd0, valid_a}, 32'd1);
        check("right_data",   {14'd0, data_a},  32'h1FFFF);
        check("right_chan",   {31'd0, chan_a},  32'd1);
        check("b_right_valid", {31'd0, valid_b}, 32'd1);
        check("b_right_data",  {14'd0, data_b},  32'h1FFFF);
        step_to(204);
        check("right_pulse_end", {31'd0, valid_a}, 32'd0);
        // Backpressure on the stereo instance.
        ready_a = 1'b0; left_word = 18'h00F0F;
        step_to(255); check("lr_t255", {31'd0, lrclk_a}, 32'd1);
        step_to(256); check("lr_t256", {31'd0, lrclk_a}, 32'd0);
        step_to(260); right_word = 18'h3C3C3;
        step_to(331);
        check("bp_valid", {31'd0, valid_a}, 32'd1);
        check("bp_data",  {14'd0, data_a},  32'h00F0F);
        step_to(384); check("lr_t384", {31'd0, lrclk_a}, 32'd1);
        step_to(458); check("bp_ovf_pre", {31'd0, overflow_a}, 32'd0);
        step_to(459);
        check("bp_ovf_set",  {31'd0, overflow_a}, 32'd1);
        check("bp_hold_data", {14'd0, data_a},    32'h00F0F);
        check("bp_hold_chan", {31'd0, chan_a},    32'd0);
        check("bp_hold_valid", {31'd0, valid_a},  32'd1);
        check("b_right2_data", {14'd0, data_b},   32'h3C3C3);
        step_to(460); ovf_clr_a = 1'b1;
        step_to(461); ovf_clr_a = 1'b0;
        check("ovf_cleared", {31'd0, overflow_a}, 32'd0);
        left_word = 18'h20001;

        // Clear requested on the same edge as a drop: the drop wins.
        step_to(586); check("ovf_pre_drop2", {31'd0, overflow_a}, 32'd0);
        ovf_clr_a = 1'b1;
        step_to(587); ovf_clr_a = 1'b0;
        check("drop_beats_clr", {31'd0, overflow_a}, 32'd1);
        check("drop2_hold_data", {14'd0, data_a},    32'h00F0F);
        step_to(600); ovf_clr_a = 1'b1; right_word = 18'h0ABCD;
        step_to(601); ovf_clr_a = 1'b0;
        check("ovf_cleared2", {31'd0, overflow_a}, 32'd0);

        // Load and transfer on the same edge.
        step_to(714);
        check("stall_data", {14'd0, data_a}, 32'h00F0F);
        ready_a = 1'b1;
        step_to(715);
        check("lt_valid", {31'd0, valid_a},    32'd1);
        check("lt_data",  {14'd0, data_a},     32'h0ABCD);
        check("lt_chan",  {31'd0, chan_a},     32'd1);
        check("lt_ovf",   {31'd0, overflow_a}, 32'd0);
        check("b_ovf",    {31'd0, overflow_b}, 32'd0);
        step_to(716);
        check("lt_drain", {31'd0, valid_a}, 32'd0);
        left_word = 18'h3FFFE;

        // Disable at left slot 9, then restart with a fresh left word.
        step_to(804); en = 1'b0;
        step_to(805);
        check("dis_bclk",  {31'd0, bclk_a},  32'd0);
        check("dis_lrclk", {31'd0, lrclk_a}, 32'd0);
        step_to(806); check("dis_bclk2", {31'd0, bclk_a}, 32'd0);
        step_to(810); left_word = 18'h12345;
        step_to(820);
        check("dis_no_valid", {31'd0, valid_a}, 32'd0);
        en = 1'b1;
        step_to(894); check("re_pre_valid", {31'd0, valid_a}, 32'd0);
        ready_a = 1'b0;
        step_to(895);
        check("re_valid", {31'd0, valid_a}, 32'd1);
        check("re_data",  {14'd0, data_a},  32'h12345);
        check("re_chan",  {31'd0, chan_a},  32'd0);

        // Reset mid-frame with a held word.
        step_to(900); rst = 1'b1; left_word = 18'h2DEAD;
        step_to(901);
        check("mrst_bclk",  {31'd0, bclk_a},     32'd0);
        check("mrst_lrclk", {31'd0, lrclk_a},    32'd0);
        check("mrst_valid", {31'd0, valid_a},    32'd0);
        check("mrst_data",  {14'd0, data_a},     32'd0);
        check("mrst_chan",  {31'd0, chan_a},     32'd0);
        check("mrst_ovf",   {31'd0, overflow_a}, 32'd0);
        step_to(903); rst = 1'b0; ready_a = 1'b1;
        step_to(977); check("post_rst_pre", {31'd0, valid_a}, 32'd0);
        step_to(978);
        check("post_rst_valid", {31'd0, valid_a}, 32'd1);
        check("post_rst_data",  {14'd0, data_a},  32'h2DEAD);
        check("post_rst_chan",  {31'd0, chan_a},  32'd0);

        check("b_word_count", n_vb,  32'd3);
        check("b_left_seen",  bad_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
I2S_RX_STEREO -- requirements
Module: i2s_rx_stereo

Interface
REQ-001 Parameter BIT_DEPTH, default 18: captured bits per channel; legal range 1..WORD_SIZE-1.
REQ-002 Parameter WORD_SIZE, default 32: BCLK periods per channel slot; legal range 2..64.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal range >= 2.
REQ-004 Parameter CH_MODE, default 0: 0 = emit both channels, 1 = left only, 2 = right only.
REQ-005 Port: clk, input, 1, the single clock; all logic SHALL be synchronous to its rising edge.
REQ-006 Port: rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-007 Port: en, input, 1, run enable for BCLK/LRCLK generation and capture.
REQ-008 Port: sd, input, 1, serial data from the microphone, already synchronised to clk.
REQ-009 Port: bclk, output, 1, registered bit clock.
REQ-010 Port: lrclk, output, 1, registered word select; 0 = left, 1 = right.
REQ-011 Port: data, output, BIT_DEPTH, captured sample, MSB-first, raw two's complement, no extension.
REQ-012 Port: chan, output, 1, channel of data; 0 = left, 1 = right.
REQ-013 Port: valid, output, 1, data/chan hold an unconsumed sample.
REQ-014 Port: ready, input, 1, consumer accepts a sample.
REQ-015 Port: overflow, output, 1, sticky flag indicating a sample was dropped.
REQ-016 Port: ovf_clr, input, 1, clears overflow.

Function
REQ-017 The divider SHALL count 0..CLK_DIV-1 while en=1 and toggle bclk when it reaches CLK_DIV-1, giving a BCLK period of 2*CLK_DIV clk cycles.
REQ-018 A rise event is the clk edge where bclk goes 0->1 and a fall event is the edge where it goes 1->0; sd SHALL be sampled only at rise events.
REQ-019 The slot index SHALL be 0..WORD_SIZE-1 and advance at each fall event; on wrap to 0 lrclk SHALL toggle at that same edge.
REQ-020 The slot index, lrclk and the shift register SHALL update only on bclk events, so for slot indices 1..BIT_DEPTH the rise-event samples SHALL shift in MSB first; slot index 0 and indices >BIT_DEPTH SHALL be ignored.
REQ-021 At the rise event of slot index BIT_DEPTH the word is complete; the load SHALL occur one clk later, setting data, chan=lrclk and valid=1.
REQ-022 Words of a channel excluded by CH_MODE SHALL never load and never affect overflow.
REQ-023 A transfer SHALL occur on any clk edge with valid=1 and ready=1; valid SHALL then clear unless a load occurs on that same edge.
REQ-024 On load with valid=1 and ready=0, the new word SHALL be dropped, data/chan SHALL be held and overflow SHALL be set.
REQ-025 On load with valid=1 and ready=1, the new word SHALL replace the old one, valid SHALL stay 1 and no overflow SHALL be raised.
REQ-026 ovf_clr=1 SHALL clear overflow next edge; a simultaneous drop SHALL take priority and leave overflow=1.
REQ-027 When en=0 at an edge, the next state SHALL be bclk=0, lrclk=0, divider=0, slot index=0, partial word discarded; data/valid/overflow SHALL be unaffected and handshakes SHALL continue.
REQ-028 When en returns to 1, a fresh left slot SHALL begin at slot index 0, with the first rise CLK_DIV cycles later.
REQ-029 data and chan SHALL be stable while valid=1 and ready=0.

Reset
REQ-030 rst=1 SHALL set bclk=0, lrclk=0, data=0, chan=0, valid=0, overflow=0, divider=0, slot index=0 and shift register=0, overriding en, ready and ovf_clr.
REQ-031 rst asserted mid-word SHALL discard the partial word; after release the block SHALL behave as in REQ-028 if en=1.

Verification
REQ-032 Reset: rst=1 for 3 cycles mid-frame -> next edge bclk=0, lrclk=0, valid=0, data=0, overflow=0.
REQ-033 Stereo (BIT_DEPTH=18, WORD_SIZE=32, CLK_DIV=2, ready=1): left 18'h2A5A5, right 18'h1FFFF -> valid 1-clk pulses with data 2A5A5/chan 0, then 1FFFF/chan 1; lrclk period 256 clk; bclk period 4 clk.
REQ-034 Backpressure: ready=0 across two words -> first word held unchanged, second dropped, overflow=1; ovf_clr pulse -> overflow=0; ready=1 -> first word transfers.
REQ-035 CH_MODE=2 with ready=1 -> only right words emitted (chan=1), one per 256 clk; no overflow.
REQ-036 en=0 at left slot index 9 -> bclk=0, lrclk=0 next edge, no valid; en=1 -> first emitted word is a complete fresh left word.
REQ-037 Load and transfer on the same edge (ready tied 1, valid already 1 from a forced stall release) -> new word visible, valid=1, overflow stays 0.
